// File: rtl/gpc_223_4_pkg.sv
// Shared widths, column weights and the result type for the (2,2,3;4) counter.
// Used by the counter core, its bus interface and the testbench.
package gpc_pkg;
    localparam int SRC0_W  = 3;
    localparam int SRC1_W  = 2;
    localparam int SRC2_W  = 2;
    localparam int DST_W   = 4;

    localparam int COL0_WT = 1;
    localparam int COL1_WT = 2;
    localparam int COL2_WT = 4;

    localparam int DST_MAX = 15;

    typedef logic [DST_W-1:0] dst_t;
endpackage

// File: rtl/gpc_223_4_if.sv
// Operand/result bundle for gpc_223_4; master drives operands, slave is the counter.
interface gpc_223_4_if;
    import gpc_pkg::*;

    logic              in_valid;
    logic [SRC0_W-1:0] src0;
    logic [SRC1_W-1:0] src1;
    logic [SRC2_W-1:0] src2;
    logic              out_valid;
    dst_t              dst;

    modport master (
        output in_valid, src0, src1, src2,
        input  out_valid, dst
    );

    modport slave (
        input  in_valid, src0, src1, src2,
        output out_valid, dst
    );
endinterface

// File: rtl/gpc_223_4_fa.sv
// Single-bit full adder: the 3:2 cell the counter is built from.
module gpc_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);
endmodule

// File: rtl/gpc_223_4.sv
// Registered (2,2,3;4) generalized parallel counter: three rippled full adders.
// Define GPC_223_4_PIPE2_EN to register after column 0 (latency 2 instead of 1).
module gpc_223_4
    import gpc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    gpc_223_4_if.slave  bus
);
    logic              w_s0, w_c0;
    logic              w_s0_q, w_c0_q, w_v_q;
    logic [SRC1_W-1:0] w_src1_q;
    logic [SRC2_W-1:0] w_src2_q;
    logic              w_s1, w_c1, w_s2, w_c2;
    logic              r_out_valid;
    dst_t              r_dst;

    gpc_fa u_fa_col0 (
        .i_a  (bus.src0[0]),
        .i_b  (bus.src0[1]),
        .i_ci (bus.src0[2]),
        .o_s  (w_s0),
        .o_co (w_c0)
    );

`ifdef GPC_223_4_PIPE2_EN
    logic              r_s0, r_c0, r_v1;
    logic [SRC1_W-1:0] r_src1;
    logic [SRC2_W-1:0] r_src2;

    // Data only loads on valid so idle X on the sources never enters the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_s0   <= 1'b0;
            r_c0   <= 1'b0;
            r_src1 <= '0;
            r_src2 <= '0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_s0   <= w_s0;
                r_c0   <= w_c0;
                r_src1 <= bus.src1;
                r_src2 <= bus.src2;
            end
        end
    end

    assign w_s0_q   = r_s0;
    assign w_c0_q   = r_c0;
    assign w_v_q    = r_v1;
    assign w_src1_q = r_src1;
    assign w_src2_q = r_src2;
`else
    assign w_s0_q   = w_s0;
    assign w_c0_q   = w_c0;
    assign w_v_q    = bus.in_valid;
    assign w_src1_q = bus.src1;
    assign w_src2_q = bus.src2;
`endif

    gpc_fa u_fa_col1 (
        .i_a  (w_src1_q[0]),
        .i_b  (w_src1_q[1]),
        .i_ci (w_c0_q),
        .o_s  (w_s1),
        .o_co (w_c1)
    );

    gpc_fa u_fa_col2 (
        .i_a  (w_src2_q[0]),
        .i_b  (w_src2_q[1]),
        .i_ci (w_c1),
        .o_s  (w_s2),
        .o_co (w_c2)
    );

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dst       <= '0;
        end else begin
            r_out_valid <= w_v_q;
            if (w_v_q) begin
                r_dst <= {w_c2, w_s2, w_s1, w_s0_q};
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dst       = r_dst;
endmodule

// File: tb/tb_gpc_223_4.sv
// Directed self-checking bench for gpc_223_4; honours GPC_223_4_PIPE2_EN for latency.
module tb_gpc_223_4;
    import gpc_pkg::*;

`ifdef GPC_223_4_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fails;

    gpc_223_4_if bus_if ();

    gpc_223_4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] ops);
        bus_if.in_valid = v;
        bus_if.src0     = ops[2:0];
        bus_if.src1     = ops[4:3];
        bus_if.src2     = ops[6:5];
    endtask

    // Reference sum from individual bit weights, independent of the adder structure.
    function automatic logic [7:0] ref_sum(input logic [6:0] v);
        int s;
        s = int'(v[0]) + int'(v[1]) + int'(v[2])
          + COL1_WT * (int'(v[3]) + int'(v[4]))
          + COL2_WT * (int'(v[5]) + int'(v[6]));
        return 8'(s);
    endfunction

    // One isolated operand set, then one idle cycle to confirm the result holds.
    task automatic apply_one(input string tag, input logic [6:0] ops, input logic [7:0] exp);
        drive(1'b1, ops);
        tick();
        bus_if.in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check({tag, "_valid"}, 8'(bus_if.out_valid), 8'd1);
        check({tag, "_dst"}, 8'(bus_if.dst), exp);
        tick();
        check({tag, "_idle_valid"}, 8'(bus_if.out_valid), 8'd0);
        check({tag, "_idle_dst"}, 8'(bus_if.dst), exp);
    endtask

    initial begin
        n_tests = 0;
        n_fails = 0;
        rst     = 1'b1;
        drive(1'b0, 7'h00);

        repeat (2) tick();
        check("reset_valid", 8'(bus_if.out_valid), 8'd0);
        check("reset_dst", 8'(bus_if.dst), 8'd0);
        rst = 1'b0;
        tick();

        // Hand-computed corner vectors.
        apply_one("zero", 7'h00, 8'd0);
        apply_one("all_ones", 7'h7f, 8'd15);
        apply_one("src0_only", 7'h07, 8'd3);
        apply_one("src1_src2", 7'h78, 8'd12);
        apply_one("pat_55", 7'h55, 8'd8);

        // Back-to-back exhaustive sweep.
        for (int i = 0; i < 128 + LAT; i++) begin
            if (i < 128) drive(1'b1, 7'(i));
            else         drive(1'b0, 7'h00);
            tick();
            if (i - (LAT - 1) >= 0 && i - (LAT - 1) < 128) begin
                check($sformatf("sweep_v_%0d", i - (LAT - 1)), 8'(bus_if.out_valid), 8'd1);
                check($sformatf("sweep_%0d", i - (LAT - 1)), 8'(bus_if.dst),
                      ref_sum(7'(i - (LAT - 1))));
            end
        end

        // Hold after 7f with idle junk and X on the sources.
        apply_one("hold_load", 7'h7f, 8'd15);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 7'($urandom_range(0, 127)));
            if (i == 3) begin
                bus_if.src0 = 'x;
                bus_if.src1 = 'x;
                bus_if.src2 = 'x;
            end
            tick();
            check($sformatf("hold_valid_%0d", i), 8'(bus_if.out_valid), 8'd0);
            check($sformatf("hold_dst_%0d", i), 8'(bus_if.dst), 8'd15);
        end

        // Reset with 7'h55 in flight.
        drive(1'b1, 7'h55);
        tick();
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", 8'(bus_if.out_valid), 8'd0);
        check("midrst_dst", 8'(bus_if.dst), 8'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            check($sformatf("postrst_valid_%0d", i), 8'(bus_if.out_valid), 8'd0);
            check($sformatf("postrst_dst_%0d", i), 8'(bus_if.dst), 8'd0);
        end
        apply_one("first_after_rst", 7'h1e, 8'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
